// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
package handshake_rr_arbiter_pkg;

  typedef enum logic {IDLE, BUSY} state_e;

  // Index width, kept at least one bit so a single requester still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Combinational rotating-priority search: first set valid bit at or above ptr,
// wrapping modulo NumReq.
module handshake_rr_pick import handshake_rr_arbiter_pkg::*; #(
  parameter int NumReq = 4,
  parameter int IdxW   = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   pick,
  output logic              any
);

  localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NumReq);

  logic [NumReq-1:0] rot;
  logic [IdxW-1:0]   off;
  logic [IdxW:0]     sum;

  // Rotate so bit 0 is the requester under the pointer.
  assign rot = NumReq'({valid, valid} >> ptr);

  always_comb begin
    off = '0;
    any = 1'b0;
    for (int k = NumReq-1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IdxW'(k);
        any = 1'b1;
      end
    end
  end

  assign sum  = {1'b0, ptr} + {1'b0, off};
  assign pick = (sum >= NumReqW) ? IdxW'(sum - NumReqW) : IdxW'(sum);

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready channel.
// Optional watchdog: define HANDSHAKE_RR_ARBITER_TIMEOUT_EN.
module handshake_rr_arbiter import handshake_rr_arbiter_pkg::*; #(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024,
  localparam int IdxW         = idx_w(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  output logic                        dst_valid_o,
  input  logic                        dst_ready_i,
  output logic [DataWidth-1:0]        dst_data_o,
  output logic [IdxW-1:0]             dst_idx_o,
  output logic                        timeout_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq-1);

  state_e               state;
  logic [IdxW-1:0]      ptr;
  logic [IdxW-1:0]      pick;
  logic                 any;
  logic                 load;
  logic                 grant;
  logic [DataWidth-1:0] data_arr [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign data_arr[i] = req_data_i[i*DataWidth +: DataWidth];
  end

  handshake_rr_pick #(.NumReq(NumReq), .IdxW(IdxW)) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr),
    .pick  (pick),
    .any   (any)
  );

  // The output register may take a new beat when empty or draining this cycle.
  assign load  = (state == IDLE) || dst_ready_i;
  assign grant = load && any && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[pick] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ptr        <= '0;
      dst_data_o <= '0;
      dst_idx_o  <= '0;
    end else if (load) begin
      if (any) begin
        state      <= BUSY;
        dst_data_o <= data_arr[pick];
        dst_idx_o  <= pick;
        ptr        <= (pick == LastIdx) ? '0 : pick + 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign dst_valid_o = (state == BUSY);

`ifdef HANDSHAKE_RR_ARBITER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] stall_cnt;
  logic            timeout_q;

  // Count stalled cycles; the flag is sticky, so the count freezes once it fires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else if (dst_valid_o && dst_ready_i) begin
      stall_cnt <= '0;
    end else if (dst_valid_o && !timeout_q) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == CntLast) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles > 0);
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed table-driven bench for handshake_rr_arbiter (NumReq=4, DataWidth=32).
module tb_handshake_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [NR-1:0]  req_valid_i;
  logic [NR-1:0]  req_ready_o;
  logic [NR*DW-1:0] req_data_i;
  logic           dst_valid_o;
  logic           dst_ready_i;
  logic [DW-1:0]  dst_data_o;
  logic [IW-1:0]  dst_idx_o;
  logic           timeout_o;

  always #5 clk_i = ~clk_i;

  handshake_rr_arbiter #(.NumReq(NR), .DataWidth(DW), .TimeoutCycles(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .dst_valid_o (dst_valid_o),
    .dst_ready_i (dst_ready_i),
    .dst_data_o  (dst_data_o),
    .dst_idx_o   (dst_idx_o),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    logic          rst;
    logic [NR-1:0] valid;
    logic          rdy;
    logic          chk;
    logic [NR-1:0] exp_ready;
    logic          exp_dv;
    logic [IW-1:0] exp_idx;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[23];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic rst, logic [NR-1:0] valid, logic rdy, logic chk,
                              logic [NR-1:0] er, logic edv, logic [IW-1:0] ei,
                              logic [DW-1:0] ed);
    vec_t v;
    v.rst = rst; v.valid = valid; v.rdy = rdy; v.chk = chk;
    v.exp_ready = er; v.exp_dv = edv; v.exp_idx = ei; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Each entry: inputs for the cycle, expected outputs observed before that edge.
    vecs[0]  = mk(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 32'h0);
    vecs[1]  = mk(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 32'h0);   // no ready during reset
    vecs[2]  = mk(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 32'h0);
    vecs[3]  = mk(0, 4'b0100, 1, 1, 4'b0100, 0, 0, 32'h0);
    vecs[4]  = mk(0, 4'b1111, 1, 1, 4'b1000, 1, 2, 32'hA2);  // ptr now 3
    vecs[5]  = mk(0, 4'b1111, 1, 1, 4'b0001, 1, 3, 32'hA3);
    vecs[6]  = mk(0, 4'b1111, 1, 1, 4'b0010, 1, 0, 32'hA0);
    vecs[7]  = mk(0, 4'b1111, 1, 1, 4'b0100, 1, 1, 32'hA1);
    vecs[8]  = mk(0, 4'b1111, 0, 1, 4'b0000, 1, 2, 32'hA2);  // stall x5
    vecs[9]  = mk(0, 4'b1111, 0, 1, 4'b0000, 1, 2, 32'hA2);
    vecs[10] = mk(0, 4'b1111, 0, 1, 4'b0000, 1, 2, 32'hA2);
    vecs[11] = mk(0, 4'b1111, 0, 1, 4'b0000, 1, 2, 32'hA2);
    vecs[12] = mk(0, 4'b1111, 0, 1, 4'b0000, 1, 2, 32'hA2);
    vecs[13] = mk(0, 4'b1111, 1, 1, 4'b1000, 1, 2, 32'hA2);  // release: back-to-back
    vecs[14] = mk(0, 4'b0001, 1, 1, 4'b0001, 1, 3, 32'hA3);  // wrap 3 -> 0
    vecs[15] = mk(0, 4'b0000, 1, 1, 4'b0000, 1, 0, 32'hA0);
    vecs[16] = mk(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 32'hA0);  // idle, ptr stays 1
    vecs[17] = mk(0, 4'b0011, 1, 1, 4'b0010, 0, 0, 32'hA0);
    vecs[18] = mk(0, 4'b0011, 0, 1, 4'b0000, 1, 1, 32'hA1);
    vecs[19] = mk(1, 4'b0011, 0, 1, 4'b0000, 1, 1, 32'hA1);  // reset while stalled
    vecs[20] = mk(0, 4'b1010, 1, 1, 4'b0010, 0, 0, 32'h0);   // ptr back to 0
    vecs[21] = mk(0, 4'b0000, 1, 1, 4'b0000, 1, 1, 32'hA1);
    vecs[22] = mk(0, 4'b0000, 1, 1, 4'b0000, 0, 1, 32'hA1);

    for (int i = 0; i < NR; i++) req_data_i[i*DW +: DW] = 32'hA0 + i;
    rst_i = 1'b1; req_valid_i = '0; dst_ready_i = 1'b1;

    for (int v = 0; v < 23; v++) begin
      @(negedge clk_i);
      rst_i = vecs[v].rst; req_valid_i = vecs[v].valid; dst_ready_i = vecs[v].rdy;
      #1;
      check($sformatf("v%0d req_ready", v), DW'(req_ready_o), DW'(vecs[v].exp_ready));
      if (vecs[v].chk) begin
        check($sformatf("v%0d dst_valid", v), DW'(dst_valid_o), DW'(vecs[v].exp_dv));
        check($sformatf("v%0d dst_idx", v), DW'(dst_idx_o), DW'(vecs[v].exp_idx));
        check($sformatf("v%0d dst_data", v), dst_data_o, vecs[v].exp_data);
        check($sformatf("v%0d timeout", v), DW'(timeout_o), 32'h0);
      end
    end

`ifdef HANDSHAKE_RR_ARBITER_TIMEOUT_EN
    // Load one beat, stall 8 edges, then drain; the flag must stick until reset.
    @(negedge clk_i);
    req_valid_i = 4'b0001; dst_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 4'b0000; dst_ready_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      check($sformatf("to stall%0d valid", k), DW'(dst_valid_o), 32'h1);
      check($sformatf("to stall%0d flag", k), DW'(timeout_o), (k >= 8) ? 32'h1 : 32'h0);
    end
    dst_ready_i = 1'b1;
    @(negedge clk_i);
    check("to after drain valid", DW'(dst_valid_o), 32'h0);
    check("to sticky", DW'(timeout_o), 32'h1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("to cleared by reset", DW'(timeout_o), 32'h0);
    rst_i = 1'b0;
`endif

    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
